ghr_pending_tracker: RTL and testbench

Parametrised global-history and pending-branch tracker for the fetch-stage branch predictor. Each cycle it accepts up to FETCH_W newly predicted conditional branches. It retires branches in order as they resolve. On a mispredict it rolls the speculative global history register (GHR) back to the mispredicted branch and inverts that branch's direction bit. It owns the pending-branch count itself and exposes a back-pressure signal, so that history is never lost while still needed for recovery.

---
 rtl/ghr_pkg.sv | 9 +
 rtl/ghr_shift_unit.sv | 43 ++++
 rtl/ghr_pending_tracker.sv | 125 ++++++++++++
 tb/tb_ghr_pending_tracker.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghr_pkg.sv
// Shared constants for the GHR / pending-branch tracker.
// Default geometry plus direction-bit and counter widths.
package ghr_pkg;
   localparam int DEF_ENTRY_W = 9;
   localparam int DEF_DEPTH   = 20;
   localparam int DEF_FETCH_W = 4;
   localparam int DIR_BIT     = 0;
   localparam int CNT_W       = 32;
endpackage

// File: rtl/ghr_shift_unit.sv
// Combinational GHR datapath: push shift/merge and
// mispredict rollback with direction-bit inversion.
module ghr_shift_unit
   import ghr_pkg::*;
#(
   parameter  int ENTRY_W = DEF_ENTRY_W,
   parameter  int DEPTH   = DEF_DEPTH,
   parameter  int FETCH_W = DEF_FETCH_W,
   localparam int G       = DEPTH * ENTRY_W,
   localparam int FW      = FETCH_W * ENTRY_W,
   localparam int PEND_W  = $clog2(DEPTH + 1),
   localparam int NUM_W   = $clog2(FETCH_W + 1)
) (
   input  logic [G-1:0]      ghr_i,
   input  logic [NUM_W-1:0]  push_num_i,
   input  logic [FW-1:0]     push_entries_i,
   input  logic [PEND_W-1:0] rb_cnt_i,
   output logic [G-1:0]      push_ghr_o,
   output logic [G-1:0]      rec_ghr_o
);

   localparam int SH_W = 16;

   logic [FW-1:0]   slot_mask;
   logic [SH_W-1:0] push_sh;
   logic [SH_W-1:0] rec_sh;

   always_comb begin
      slot_mask = '0;
      for (int s = 0; s < FETCH_W; s++) begin
         if (NUM_W'(s) < push_num_i)
            slot_mask[s*ENTRY_W +: ENTRY_W] = '1;
      end
      push_sh = SH_W'(push_num_i) * SH_W'(ENTRY_W);
      rec_sh  = SH_W'(rb_cnt_i) * SH_W'(ENTRY_W);
      // Logical shifts by >= G yield zero, so no wrap-around.
      push_ghr_o = (ghr_i << push_sh)
                 | G'(push_entries_i & slot_mask);
      rec_ghr_o  = ghr_i >> rec_sh;
      rec_ghr_o[DIR_BIT] = ~rec_ghr_o[DIR_BIT];
   end

endmodule

// File: rtl/ghr_pending_tracker.sv
// Speculative GHR and pending-branch tracker with back-pressure.
// Optional GHR_MISP_CNT_EN adds mispredict/resolve counters.
module ghr_pending_tracker
   import ghr_pkg::*;
#(
   parameter  int ENTRY_W = DEF_ENTRY_W,
   parameter  int DEPTH   = DEF_DEPTH,
   parameter  int FETCH_W = DEF_FETCH_W,
   localparam int PEND_W  = $clog2(DEPTH + 1),
   localparam int NUM_W   = $clog2(FETCH_W + 1)
) (
   input  logic                       fire,
   input  logic                       rst,
   input  logic                       i_pushValid,
   input  logic [NUM_W-1:0]           i_pushNum,
   input  logic [FETCH_W*ENTRY_W-1:0] i_pushEntries,
   input  logic                       i_resolveValid,
   input  logic                       i_resolveMisp,
   output logic                       o_ready,
   output logic [PEND_W-1:0]          o_pendingB,
   output logic [DEPTH*ENTRY_W-1:0]   o_ghr,
   output logic                       o_err
`ifdef GHR_MISP_CNT_EN
   ,
   output logic [CNT_W-1:0]           o_mispCnt,
   output logic [CNT_W-1:0]           o_resolveCnt
`endif
);

   localparam int G     = DEPTH * ENTRY_W;
   localparam int SUM_W = PEND_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
   localparam logic [SUM_W-1:0] FETCH_S = SUM_W'(FETCH_W);
   localparam logic [NUM_W-1:0] FETCH_N = NUM_W'(FETCH_W);

   logic [G-1:0]      ghr_q, ghr_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              err_q, err_d;

   logic [G-1:0]      push_ghr, rec_ghr;
   logic [PEND_W-1:0] pend_eff;
   logic [SUM_W-1:0]  pend_sum;
   logic              res_ok, misp, corr;
   logic              push_req, fits, push_ok;

   ghr_shift_unit #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH),
      .FETCH_W (FETCH_W)
   ) u_shift (
      .ghr_i          (ghr_q),
      .push_num_i     (i_pushNum),
      .push_entries_i (i_pushEntries),
      .rb_cnt_i       (pend_q - PEND_W'(1)),
      .push_ghr_o     (push_ghr),
      .rec_ghr_o      (rec_ghr)
   );

   always_comb begin
      res_ok   = i_resolveValid && (pend_q != '0);
      misp     = res_ok && i_resolveMisp;
      corr     = res_ok && !i_resolveMisp;
      pend_eff = pend_q - PEND_W'(corr);
      pend_sum = {1'b0, pend_eff} + SUM_W'(i_pushNum);
      // Wrong-path pushes under a mispredict are dropped silently.
      push_req = i_pushValid && (i_pushNum != '0) && !misp;
      fits     = (i_pushNum <= FETCH_N) && (pend_sum <= DEPTH_S);
      push_ok  = push_req && fits;

      ghr_d  = ghr_q;
      pend_d = pend_eff;
      if (misp) begin
         ghr_d  = rec_ghr;
         pend_d = '0;
      end else if (push_ok) begin
         ghr_d  = push_ghr;
         pend_d = pend_sum[PEND_W-1:0];
      end

      err_d = err_q
            | (push_req && !fits)
            | (i_resolveValid && (pend_q == '0));
   end

   always_ff @(posedge fire) begin
      if (rst) begin
         ghr_q  <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         ghr_q  <= ghr_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign o_ready    = ({1'b0, pend_q} + FETCH_S) <= DEPTH_S;
   assign o_pendingB = pend_q;
   assign o_ghr      = ghr_q;
   assign o_err      = err_q;

`ifdef GHR_MISP_CNT_EN
   logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
   logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

   always_comb begin
      misp_cnt_d = misp_cnt_q + CNT_W'(misp);
      res_cnt_d  = res_cnt_q + CNT_W'(res_ok);
   end

   always_ff @(posedge fire) begin
      if (rst) begin
         misp_cnt_q <= '0;
         res_cnt_q  <= '0;
      end else begin
         misp_cnt_q <= misp_cnt_d;
         res_cnt_q  <= res_cnt_d;
      end
   end

   assign o_mispCnt    = misp_cnt_q;
   assign o_resolveCnt = res_cnt_q;
`endif

endmodule

// File: tb/tb_ghr_pending_tracker.sv
// Directed self-checking bench for ghr_pending_tracker.
// Counter checks are compiled in with GHR_MISP_CNT_EN.
module tb_ghr_pending_tracker;

   logic         fire = 1'b0;
   logic         rst;
   logic         i_pushValid;
   logic [2:0]   i_pushNum;
   logic [35:0]  i_pushEntries;
   logic         i_resolveValid;
   logic         i_resolveMisp;
   logic         o_ready;
   logic [4:0]   o_pendingB;
   logic [179:0] o_ghr;
   logic         o_err;
`ifdef GHR_MISP_CNT_EN
   logic [31:0]  o_mispCnt;
   logic [31:0]  o_resolveCnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   logic [179:0] m_ghr;

   ghr_pending_tracker dut (
      .fire           (fire),
      .rst            (rst),
      .i_pushValid    (i_pushValid),
      .i_pushNum      (i_pushNum),
      .i_pushEntries  (i_pushEntries),
      .i_resolveValid (i_resolveValid),
      .i_resolveMisp  (i_resolveMisp),
      .o_ready        (o_ready),
      .o_pendingB     (o_pendingB),
      .o_ghr          (o_ghr),
      .o_err          (o_err)
`ifdef GHR_MISP_CNT_EN
      ,
      .o_mispCnt      (o_mispCnt),
      .o_resolveCnt   (o_resolveCnt)
`endif
   );

   always #5 fire = ~fire;

   function automatic logic [179:0] mdl_push(
      input logic [179:0] g, input int n, input logic [35:0] e);
      logic [179:0] r;
      r = g << (n * 9);
      for (int s = 0; s < n; s++) r[s*9 +: 9] = e[s*9 +: 9];
      return r;
   endfunction

   task automatic cyc(input logic pv, input logic [2:0] n,
                      input logic [35:0] e,
                      input logic rv, input logic rm);
      i_pushValid    = pv;
      i_pushNum      = n;
      i_pushEntries  = e;
      i_resolveValid = rv;
      i_resolveMisp  = rm;
      @(posedge fire);
      #1;
      i_pushValid    = 1'b0;
      i_pushNum      = '0;
      i_pushEntries  = '0;
      i_resolveValid = 1'b0;
      i_resolveMisp  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge fire);
      #1;
      rst = 1'b0;
      m_ghr = '0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (o_pendingB !== 5'd0) begin
         n_fail++;
         $display("FAIL rst_pend: got %0d want 0", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== 180'h0) begin
         n_fail++;
         $display("FAIL rst_ghr: got %h want 0", o_ghr);
      end
      n_chk++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 1", o_ready);
      end
      n_chk++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_err: got %b want 0", o_err);
      end
   endtask

   task automatic test_push_merge();
      cyc(1'b1, 3'd2, {9'h1FF, 9'h1FF, 9'h1A3, 9'h055}, 1'b0, 1'b0);
      n_chk++;
      if (o_ghr !== 180'({9'h1A3, 9'h055})) begin
         n_fail++;
         $display("FAIL merge_ghr: got %h want %h", o_ghr,
                  180'({9'h1A3, 9'h055}));
      end
      n_chk++;
      if (o_pendingB !== 5'd2) begin
         n_fail++;
         $display("FAIL merge_pend: got %0d want 2", o_pendingB);
      end
   endtask

   task automatic test_push_resolve();
      cyc(1'b1, 3'd1, {9'h1FF, 9'h1FF, 9'h1FF, 9'h0F0}, 1'b1, 1'b0);
      n_chk++;
      if (o_pendingB !== 5'd2) begin
         n_fail++;
         $display("FAIL pr_pend: got %0d want 2", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== 180'({9'h1A3, 9'h055, 9'h0F0})) begin
         n_fail++;
         $display("FAIL pr_ghr: got %h want %h", o_ghr,
                  180'({9'h1A3, 9'h055, 9'h0F0}));
      end
      n_chk++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pr_err: got %b want 0", o_err);
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      cyc(1'b1, 3'd1, 36'h101, 1'b0, 1'b0);
      cyc(1'b1, 3'd1, 36'h002, 1'b0, 1'b0);
      cyc(1'b1, 3'd1, 36'h003, 1'b0, 1'b0);
      n_chk++;
      if (o_pendingB !== 5'd3) begin
         n_fail++;
         $display("FAIL misp_pre_pend: got %0d want 3", o_pendingB);
      end
      cyc(1'b1, 3'd1, 36'h1FF, 1'b1, 1'b1);
      n_chk++;
      if (o_ghr !== 180'h100) begin
         n_fail++;
         $display("FAIL misp_ghr: got %h want 100", o_ghr);
      end
      n_chk++;
      if (o_pendingB !== 5'd0) begin
         n_fail++;
         $display("FAIL misp_pend: got %0d want 0", o_pendingB);
      end
      n_chk++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL misp_err: got %b want 0", o_err);
      end
`ifdef GHR_MISP_CNT_EN
      n_chk++;
      if (o_mispCnt !== 32'd1) begin
         n_fail++;
         $display("FAIL misp_cnt: got %0d want 1", o_mispCnt);
      end
      n_chk++;
      if (o_resolveCnt !== 32'd1) begin
         n_fail++;
         $display("FAIL res_cnt: got %0d want 1", o_resolveCnt);
      end
`endif
   endtask

   task automatic test_capacity();
      logic [35:0]  e;
      logic [179:0] exp_g;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         e = {9'(4*k+4), 9'(4*k+3), 9'(4*k+2), 9'(4*k+1)};
         cyc(1'b1, 3'd4, e, 1'b0, 1'b0);
         m_ghr = mdl_push(m_ghr, 4, e);
      end
      n_chk++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cap16_ready: got %b want 1", o_ready);
      end
      e = {9'h1FF, 9'h1FF, 9'h1FF, 9'h0AA};
      cyc(1'b1, 3'd1, e, 1'b0, 1'b0);
      m_ghr = mdl_push(m_ghr, 1, e);
      n_chk++;
      if (o_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cap17_ready: got %b want 0", o_ready);
      end
      n_chk++;
      if (o_pendingB !== 5'd17) begin
         n_fail++;
         $display("FAIL cap17_pend: got %0d want 17", o_pendingB);
      end
      cyc(1'b1, 3'd4, 36'hFFFFFFFFF, 1'b0, 1'b0);
      n_chk++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cap_drop_err: got %b want 1", o_err);
      end
      n_chk++;
      if (o_pendingB !== 5'd17) begin
         n_fail++;
         $display("FAIL cap_drop_pend: got %0d want 17", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== m_ghr) begin
         n_fail++;
         $display("FAIL cap_drop_ghr: got %h want %h", o_ghr, m_ghr);
      end
      e = {9'h1FF, 9'h033, 9'h022, 9'h011};
      cyc(1'b1, 3'd3, e, 1'b0, 1'b0);
      m_ghr = mdl_push(m_ghr, 3, e);
      n_chk++;
      if (o_pendingB !== 5'd20) begin
         n_fail++;
         $display("FAIL cap_fill_pend: got %0d want 20", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== m_ghr) begin
         n_fail++;
         $display("FAIL cap_fill_ghr: got %h want %h", o_ghr, m_ghr);
      end
      n_chk++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cap_fill_err: got %b want 1", o_err);
      end
      // Oldest of 20 pending entries becomes the only one left.
      exp_g = m_ghr >> (19 * 9);
      exp_g[0] = ~exp_g[0];
      cyc(1'b0, 3'd0, 36'h0, 1'b1, 1'b1);
      n_chk++;
      if (o_ghr !== exp_g) begin
         n_fail++;
         $display("FAIL cap_misp_ghr: got %h want %h", o_ghr, exp_g);
      end
      n_chk++;
      if (o_pendingB !== 5'd0) begin
         n_fail++;
         $display("FAIL cap_misp_pend: got %0d want 0", o_pendingB);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      cyc(1'b0, 3'd0, 36'h0, 1'b1, 1'b0);
      n_chk++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL uf_err: got %b want 1", o_err);
      end
      n_chk++;
      if (o_pendingB !== 5'd0) begin
         n_fail++;
         $display("FAIL uf_pend: got %0d want 0", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== 180'h0) begin
         n_fail++;
         $display("FAIL uf_ghr: got %h want 0", o_ghr);
      end
      cyc(1'b1, 3'd1, {9'h1FF, 9'h1FF, 9'h1FF, 9'h0AB}, 1'b1, 1'b1);
      n_chk++;
      if (o_pendingB !== 5'd1) begin
         n_fail++;
         $display("FAIL uf_push_pend: got %0d want 1", o_pendingB);
      end
      n_chk++;
      if (o_ghr !== 180'h0AB) begin
         n_fail++;
         $display("FAIL uf_push_ghr: got %h want 0ab", o_ghr);
      end
      cyc(1'b0, 3'd0, 36'h0, 1'b1, 1'b1);
      n_chk++;
      if (o_ghr !== 180'h0AA) begin
         n_fail++;
         $display("FAIL misp1_ghr: got %h want 0aa", o_ghr);
      end
   endtask

   task automatic test_reset_wins();
      cyc(1'b1, 3'd2, 36'h0123, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b1, 3'd2, 36'h0456, 1'b1, 1'b0);
      rst = 1'b0;
      n_chk++;
      if (o_pendingB !== 5'd0 || o_ghr !== 180'h0 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wins: got pend=%0d ghr=%h err=%b want 0/0/0",
                  o_pendingB, o_ghr, o_err);
      end
   endtask

   initial begin
      rst            = 1'b1;
      i_pushValid    = 1'b0;
      i_pushNum      = '0;
      i_pushEntries  = '0;
      i_resolveValid = 1'b0;
      i_resolveMisp  = 1'b0;
      m_ghr          = '0;
      test_reset();
      test_push_merge();
      test_push_resolve();
      test_mispredict();
      test_capacity();
      test_underflow();
      test_reset_wins();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
